// File: rtl/fan_pwm_ctrl.sv
// Soft-start PWM fan controller: full-duty kick, ramp to target, steady run, glitch-free retargeting.
// Define FAN_TACH_EN to add tach edge counting per window and stall detection in RUN.
module fan_pwm_ctrl #(
    parameter int DUTY_W          = 8,
    parameter int KICK_FRAMES     = 4,
    parameter int RAMP_FRAMES     = 1,
    parameter int MIN_DUTY        = 32,
    parameter int TACH_WIN_FRAMES = 64
) (
    input  logic              axi_aclk,
    input  logic              axi_areset,
    input  logic              enable,
    input  logic [15:0]       prescale,
    input  logic [DUTY_W-1:0] duty_target,
    input  logic              tach_in,
    output logic              fan_pwm,
    output logic [DUTY_W-1:0] duty_cur,
    output logic [1:0]        state,
    output logic              frame_tick,
    output logic [15:0]       tach_count,
    output logic              stall
);
    localparam logic [DUTY_W-1:0] MAX   = '1;
    localparam logic [DUTY_W-1:0] MIN_D = DUTY_W'(MIN_DUTY);
    localparam int FC_MAX = (KICK_FRAMES > RAMP_FRAMES) ? KICK_FRAMES : RAMP_FRAMES;
    localparam int FC_W   = (FC_MAX > 1) ? $clog2(FC_MAX) : 1;
    localparam logic [FC_W-1:0] KICK_LAST = FC_W'(KICK_FRAMES - 1);
    localparam logic [FC_W-1:0] RAMP_LAST = FC_W'(RAMP_FRAMES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, KICK = 2'd1, RAMP = 2'd2, RUN = 2'd3} state_t;

    state_t            st;
    logic [15:0]       pre_cnt, prescale_q;
    logic [DUTY_W-1:0] step_cnt, target_q, tgt, duty_step;
    logic [FC_W-1:0]   frame_cnt;
    logic              step_tick, frame_end;

    assign state = st;

    always_comb begin
        step_tick = (st != IDLE) && (pre_cnt == prescale_q);
        frame_end = step_tick && (step_cnt == MAX);
        // Non-zero targets below the stall threshold are lifted to MIN_DUTY.
        tgt = ((target_q != '0) && (target_q < MIN_D)) ? MIN_D : target_q;
        duty_step = duty_cur;
        if (duty_cur < tgt)
            duty_step = duty_cur + DUTY_W'(1);
        else if (duty_cur > tgt)
            duty_step = duty_cur - DUTY_W'(1);
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            st         <= IDLE;
            duty_cur   <= '0;
            fan_pwm    <= 1'b0;
            frame_tick <= 1'b0;
            pre_cnt    <= '0;
            step_cnt   <= '0;
            frame_cnt  <= '0;
            prescale_q <= '0;
            target_q   <= '0;
        end else if (!enable) begin
            st         <= IDLE;
            duty_cur   <= '0;
            fan_pwm    <= 1'b0;
            frame_tick <= 1'b0;
            pre_cnt    <= '0;
            step_cnt   <= '0;
            frame_cnt  <= '0;
        end else begin
            frame_tick <= frame_end;
            fan_pwm    <= (duty_cur == MAX) || (step_cnt < duty_cur);
            if (st == IDLE) begin
                st         <= KICK;
                duty_cur   <= MAX;
                frame_cnt  <= '0;
                pre_cnt    <= '0;
                step_cnt   <= '0;
                prescale_q <= prescale;
                target_q   <= duty_target;
            end else begin
                if (step_tick) begin
                    pre_cnt  <= '0;
                    step_cnt <= step_cnt + DUTY_W'(1);
                end else begin
                    pre_cnt <= pre_cnt + 16'd1;
                end
                // Decisions use the target sampled at the previous frame boundary.
                if (frame_end) begin
                    prescale_q <= prescale;
                    target_q   <= duty_target;
                    case (st)
                        KICK: begin
                            if (frame_cnt == KICK_LAST) begin
                                frame_cnt <= '0;
                                st        <= (tgt == MAX) ? RUN : RAMP;
                            end else begin
                                frame_cnt <= frame_cnt + FC_W'(1);
                            end
                        end
                        RAMP: begin
                            if (frame_cnt == RAMP_LAST) begin
                                frame_cnt <= '0;
                                duty_cur  <= duty_step;
                                if (duty_step == tgt)
                                    st <= RUN;
                            end else begin
                                frame_cnt <= frame_cnt + FC_W'(1);
                            end
                        end
                        RUN: begin
                            if (tgt != duty_cur) begin
                                st        <= RAMP;
                                frame_cnt <= '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef FAN_TACH_EN
    localparam int WIN_W = (TACH_WIN_FRAMES > 1) ? $clog2(TACH_WIN_FRAMES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(TACH_WIN_FRAMES - 1);

    logic [2:0]       tach_sync;
    logic [15:0]      edge_cnt;
    logic [WIN_W-1:0] win_cnt;
    logic             tach_rise, win_end;

    // tach_sync[1:0] is the synchronizer, tach_sync[2] the edge-detect history.
    assign tach_rise = tach_sync[1] & ~tach_sync[2];
    assign win_end   = frame_end && (win_cnt == WIN_LAST);

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            tach_sync  <= '0;
            edge_cnt   <= '0;
            win_cnt    <= '0;
            tach_count <= '0;
            stall      <= 1'b0;
        end else begin
            tach_sync <= {tach_sync[1:0], tach_in};
            if (!enable || st == IDLE) begin
                edge_cnt <= '0;
                win_cnt  <= '0;
                stall    <= 1'b0;
            end else begin
                if (frame_end)
                    win_cnt <= win_end ? '0 : win_cnt + WIN_W'(1);
                if (win_end) begin
                    tach_count <= edge_cnt;
                    stall      <= (st == RUN) && (edge_cnt == '0);
                    edge_cnt   <= {15'd0, tach_rise};
                end else if (tach_rise && edge_cnt != '1) begin
                    edge_cnt <= edge_cnt + 16'd1;
                end
            end
        end
    end
`else
    logic unused_tach;
    assign unused_tach = tach_in | (TACH_WIN_FRAMES == 0);
    assign tach_count  = '0;
    assign stall       = 1'b0;
`endif

endmodule

// File: tb/tb_fan_pwm_ctrl.sv
// Bench for fan_pwm_ctrl: vector table of segments plus a frame-position reference model checked every clock.
module tb_fan_pwm_ctrl;
    localparam int DW   = 8;
    localparam int KF   = 2;
    localparam int RF   = 1;
    localparam int MIND = 32;
    localparam int TW   = 4;
    localparam int MAXD = 255;
    localparam int FSTEPS = 256;

    logic        axi_aclk = 1'b0;
    logic        axi_areset = 1'b1;
    logic        enable = 1'b0;
    logic        tach_in = 1'b0;
    logic [15:0] prescale = 16'd0;
    logic [7:0]  duty_target = 8'd0;
    logic        fan_pwm, frame_tick, stall;
    logic [7:0]  duty_cur;
    logic [1:0]  state;
    logic [15:0] tach_count;

    fan_pwm_ctrl #(.DUTY_W(DW), .KICK_FRAMES(KF), .RAMP_FRAMES(RF), .MIN_DUTY(MIND),
                   .TACH_WIN_FRAMES(TW)) dut (
        .axi_aclk(axi_aclk), .axi_areset(axi_areset), .enable(enable), .prescale(prescale),
        .duty_target(duty_target), .tach_in(tach_in), .fan_pwm(fan_pwm), .duty_cur(duty_cur),
        .state(state), .frame_tick(frame_tick), .tach_count(tach_count), .stall(stall));

    always #5 axi_aclk = ~axi_aclk;

    int errors = 0;
    int checks = 0;

    // Reference model: position within the frame in clocks, frames completed in the current phase.
    int ms, md, mpos, mpq, mtq, mfr;
    bit mpwm, mtick;

    function automatic int eff(int t);
        return (t != 0 && t < MIND) ? MIND : t;
    endfunction

    function automatic void model_reset();
        ms = 0; md = 0; mpos = 0; mpq = 0; mtq = 0; mfr = 0; mpwm = 0; mtick = 0;
    endfunction

    function automatic void model_step();
        int flen, step, t;
        bit fe;
        if (axi_areset) begin
            model_reset();
            return;
        end
        if (!enable) begin
            ms = 0; md = 0; mpos = 0; mfr = 0; mpwm = 0; mtick = 0;
            return;
        end
        if (ms == 0) begin
            ms = 1; md = MAXD; mpos = 0; mfr = 0; mpq = prescale; mtq = duty_target;
            mpwm = 0; mtick = 0;
            return;
        end
        flen = (mpq + 1) * FSTEPS;
        step = mpos / (mpq + 1);
        mpwm = (md == MAXD) || (step < md);
        fe = (mpos == flen - 1);
        mtick = fe;
        mpos = fe ? 0 : mpos + 1;
        if (fe) begin
            t = eff(mtq);
            case (ms)
                1: begin
                    mfr++;
                    if (mfr == KF) begin mfr = 0; ms = (t == MAXD) ? 3 : 2; end
                end
                2: begin
                    mfr++;
                    if (mfr == RF) begin
                        mfr = 0;
                        md = md + ((t > md) ? 1 : ((t < md) ? -1 : 0));
                        if (md == t) ms = 3;
                    end
                end
                default: if (t != md) begin ms = 2; mfr = 0; end
            endcase
            mpq = prescale;
            mtq = duty_target;
        end
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge axi_aclk);
        model_step();
        #1;
        checks++;
        if ({state, duty_cur, fan_pwm, frame_tick} !== {2'(ms), 8'(md), mpwm, mtick}) begin
            errors++;
            $display("FAIL cyc: state/duty/pwm/tick got %0d/%0d/%0b/%0b expected %0d/%0d/%0b/%0b at %0t",
                     state, duty_cur, fan_pwm, frame_tick, ms, md, mpwm, mtick, $time);
        end
`ifndef FAN_TACH_EN
        checks++;
        if (tach_count !== 16'd0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL tach_off: tach_count=%0d stall=%0b expected 0/0 at %0t", tach_count, stall, $time);
        end
`endif
    endtask

    task automatic run(int n);
        repeat (n) cycle();
    endtask

    typedef struct {
        bit en; int pre; int tgt; int n; int st; int duty;
    } vec_t;

    vec_t vec[16];

    initial begin
        int lows, gap;
        vec[0]  = '{0, 0, 128, 5, 0, 0};
        vec[1]  = '{1, 0, 128, 1, 1, 255};
        vec[2]  = '{1, 0, 128, 511, 1, 255};
        vec[3]  = '{1, 0, 128, 1, 2, 255};
        vec[4]  = '{1, 0, 128, 256, 2, 254};
        vec[5]  = '{1, 0, 128, 256 * 126, 3, 128};
        vec[6]  = '{1, 0, 130, 100, 3, 128};
        vec[7]  = '{1, 0, 130, 156, 3, 128};
        vec[8]  = '{1, 0, 130, 256, 2, 128};
        vec[9]  = '{1, 0, 130, 256, 2, 129};
        vec[10] = '{1, 0, 130, 256, 3, 130};
        vec[11] = '{1, 0, 10, 512, 2, 130};
        vec[12] = '{1, 0, 10, 256 * 98, 3, 32};
        vec[13] = '{1, 0, 0, 512, 2, 32};
        vec[14] = '{1, 0, 0, 256 * 32, 3, 0};
        vec[15] = '{0, 0, 0, 1, 0, 0};

        model_reset();
        repeat (3) @(posedge axi_aclk);
        #1;
        check("rst_state", state, 0);
        check("rst_duty", duty_cur, 0);
        check("rst_pwm", fan_pwm, 0);
        check("rst_tick", frame_tick, 0);
        check("rst_tach", tach_count, 0);
        check("rst_stall", stall, 0);
        axi_areset = 1'b0;

        foreach (vec[i]) begin
            enable = vec[i].en; prescale = 16'(vec[i].pre); duty_target = 8'(vec[i].tgt);
            run(vec[i].n);
            check($sformatf("vec%0d_state", i), state, vec[i].st);
            check($sformatf("vec%0d_duty", i), duty_cur, vec[i].duty);
            if (i == 14) begin
                lows = 0;
                for (int k = 0; k < 300; k++) begin cycle(); lows += fan_pwm; end
                check("duty0_highs", lows, 0);
            end
        end

        // Full target: kick goes straight to RUN, output never drops across frame wraps.
        duty_target = 8'd255; enable = 1'b1;
        run(513);
        check("kick_to_run", state, 3);
        lows = 0;
        for (int k = 0; k < 600; k++) begin cycle(); lows += (fan_pwm == 1'b0); end
        check("duty255_lows", lows, 0);

        // prescale=3 stretches the frame to 1024 clocks.
        enable = 1'b0; run(1);
        prescale = 16'd3; enable = 1'b1;
        for (int k = 0; k < 2000 && !frame_tick; k++) cycle();
        check("tick_seen", frame_tick, 1);
        gap = 0;
        do begin cycle(); gap++; end while (!frame_tick && gap < 2000);
        check("tick_period", gap, 1024);

        // Abort in KICK on the frame_end cycle.
        enable = 1'b0; run(1);
        prescale = 16'd0; duty_target = 8'd40; enable = 1'b1;
        run(1);
        check("kick_enter", state, 1);
        run(255);
        enable = 1'b0; run(1);
        check("abort_kick_state", state, 0);
        check("abort_kick_duty", duty_cur, 0);
        check("abort_kick_pwm", fan_pwm, 0);
        check("abort_kick_tick", frame_tick, 0);

        // Re-enable, then abort in RAMP on the frame_end cycle.
        enable = 1'b1; run(1);
        check("rekick_state", state, 1);
        check("rekick_duty", duty_cur, 255);
        run(512);
        check("ramp_enter", state, 2);
        run(255);
        enable = 1'b0; run(1);
        check("abort_ramp_state", state, 0);
        check("abort_ramp_duty", duty_cur, 0);
        check("abort_ramp_pwm", fan_pwm, 0);

        // Asynchronous reset mid-RAMP with enable held high.
        enable = 1'b1; run(813);
        check("pre_rst_state", state, 2);
        #3 axi_areset = 1'b1;
        #1;
        check("arst_state", state, 0);
        check("arst_duty", duty_cur, 0);
        check("arst_pwm", fan_pwm, 0);
        check("arst_tick", frame_tick, 0);
        model_reset();
        run(2);
        axi_areset = 1'b0;
        #2;
        check("rel_idle", state, 0);
        cycle();
        check("rel_kick", state, 1);

        // Randomized segments against the model.
        for (int r = 0; r < 25; r++) begin
            enable = ($urandom_range(0, 15) != 0);
            prescale = 16'($urandom_range(0, 1));
            duty_target = 8'($urandom_range(0, 255));
            run($urandom_range(1, 300));
        end

`ifdef FAN_TACH_EN
        begin
            int ticks, wcyc, budget;
            enable = 1'b0; run(2);
            prescale = 16'd0; duty_target = 8'd255; enable = 1'b1;
            ticks = 0; wcyc = 0; budget = 0;
            while (ticks < 12 && budget < 4000) begin
                tach_in = (ticks < 8) && ((wcyc >= 100 && wcyc < 120) ||
                          (wcyc >= 300 && wcyc < 320) || (wcyc >= 500 && wcyc < 520));
                cycle(); budget++; wcyc++;
                if (frame_tick) begin
                    ticks++;
                    if (ticks % 4 == 0) begin
                        wcyc = 0;
                        check($sformatf("tach_cnt_w%0d", ticks / 4), tach_count, (ticks < 12) ? 3 : 0);
                        check($sformatf("stall_w%0d", ticks / 4), stall, (ticks < 12) ? 0 : 1);
                    end
                end
            end
            check("tach_windows", ticks, 12);
            tach_in = 1'b0; enable = 1'b0;
            run(2);
            check("stall_clear", stall, 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
